// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control path:
// ALU ops and sources, FSM states, PC/regfile selects, opcodes and functs.
package multicycle_control_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_NOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    localparam logic [1:0] ALU_SRC_REG        = 2'd0;
    localparam logic [1:0] ALU_SRC_SEXT_IMM16 = 2'd1;
    localparam logic [1:0] ALU_SRC_ZEXT_IMM16 = 2'd2;
    localparam logic [1:0] ALU_SRC_SHAMT      = 2'd3;

    localparam logic [3:0] STATE_RESET     = 4'd0;
    localparam logic [3:0] STATE_FETCH     = 4'd1;
    localparam logic [3:0] STATE_DECODE    = 4'd2;
    localparam logic [3:0] STATE_EXEC      = 4'd3;
    localparam logic [3:0] STATE_WB_ALU    = 4'd4;
    localparam logic [3:0] STATE_MEM_ADDR  = 4'd5;
    localparam logic [3:0] STATE_MEM_READ  = 4'd6;
    localparam logic [3:0] STATE_MEM_WB    = 4'd7;
    localparam logic [3:0] STATE_MEM_WRITE = 4'd8;
    localparam logic [3:0] STATE_BRANCH    = 4'd9;
    localparam logic [3:0] STATE_JUMP      = 4'd10;
    localparam logic [3:0] STATE_TRAP      = 4'd11;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP26 = 2'd2;
    localparam logic [1:0] PC_SRC_REG    = 2'd3;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] WB_SRC_ALU = 2'd0;
    localparam logic [1:0] WB_SRC_MEM = 2'd1;
    localparam logic [1:0] WB_SRC_PC  = 2'd2;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// Opcode/funct to ALU control map; legal is set only for ALU-class
// instructions (R-type arithmetic/shift and the three immediates).
module mc_alu_decode
    import multicycle_control_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic [1:0] alu_src,
    output logic       legal
);

    always_comb begin
        alu_op  = OP_ADD;
        alu_src = ALU_SRC_REG;
        legal   = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                legal = 1'b1;
                case (funct)
                    FN_ADD: alu_op = OP_ADD;
                    FN_SUB: alu_op = OP_SUB;
                    FN_AND: alu_op = OP_AND;
                    FN_OR:  alu_op = OP_OR;
                    FN_NOR: alu_op = OP_NOR;
                    FN_SLT: alu_op = OP_SLT;
                    FN_SLL: begin
                        alu_op  = OP_SLL;
                        alu_src = ALU_SRC_SHAMT;
                    end
                    FN_SRL: begin
                        alu_op  = OP_SRL;
                        alu_src = ALU_SRC_SHAMT;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_ADDI: begin
                legal   = 1'b1;
                alu_op  = OP_ADD;
                alu_src = ALU_SRC_SEXT_IMM16;
            end
            OPC_ANDI: begin
                legal   = 1'b1;
                alu_op  = OP_AND;
                alu_src = ALU_SRC_ZEXT_IMM16;
            end
            OPC_ORI: begin
                legal   = 1'b1;
                alu_op  = OP_OR;
                alu_src = ALU_SRC_ZEXT_IMM16;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: one memory port and one ALU shared across
// fetch/execute/memory/write-back; all strobes decoded from the state.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_src,
    output logic [1:0]  alu_src,
    output logic [2:0]  alu_op,
    output logic        illegal,
    output logic [3:0]  state
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [2:0] dec_op;
    logic [1:0] dec_src;
    logic       dec_legal;
    logic       is_rtype;
    logic       is_jr;
    logic [3:0] next;
    logic       unused;

    assign opcode   = instruction[31:26];
    assign funct    = instruction[5:0];
    assign is_rtype = (opcode == OPC_RTYPE);
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign unused   = ^instruction[25:6];

    mc_alu_decode u_dec (
        .opcode  (opcode),
        .funct   (funct),
        .alu_op  (dec_op),
        .alu_src (dec_src),
        .legal   (dec_legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= STATE_RESET;
        else       state <= next;
    end

    always_comb begin
        next         = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_PLUS4;
        reg_write    = 1'b0;
        reg_dst      = REG_DST_RT;
        wb_src       = WB_SRC_ALU;
        alu_src      = ALU_SRC_REG;
        alu_op       = OP_ADD;
        illegal      = 1'b0;
        case (state)
            STATE_RESET: next = STATE_FETCH;
            STATE_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_PLUS4;
                    next     = STATE_DECODE;
                end
            end
            STATE_DECODE: begin
                if (dec_legal)
                    next = STATE_EXEC;
                else if (opcode == OPC_LW || opcode == OPC_SW)
                    next = STATE_MEM_ADDR;
                else if (opcode == OPC_BEQ || opcode == OPC_BNE)
                    next = STATE_BRANCH;
                else if (opcode == OPC_J || opcode == OPC_JAL || is_jr)
                    next = STATE_JUMP;
                else
                    next = STATE_TRAP;
            end
            STATE_EXEC: begin
                alu_op  = dec_op;
                alu_src = dec_src;
                next    = STATE_WB_ALU;
            end
            STATE_WB_ALU: begin
                alu_op    = dec_op;
                alu_src   = dec_src;
                reg_write = 1'b1;
                wb_src    = WB_SRC_ALU;
                reg_dst   = is_rtype ? REG_DST_RD : REG_DST_RT;
                next      = STATE_FETCH;
            end
            STATE_MEM_ADDR: begin
                alu_op  = OP_ADD;
                alu_src = ALU_SRC_SEXT_IMM16;
                next    = (opcode == OPC_SW) ? STATE_MEM_WRITE
                                             : STATE_MEM_READ;
            end
            STATE_MEM_READ: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) next = STATE_MEM_WB;
            end
            STATE_MEM_WB: begin
                reg_write = 1'b1;
                wb_src    = WB_SRC_MEM;
                reg_dst   = REG_DST_RT;
                next      = STATE_FETCH;
            end
            STATE_MEM_WRITE: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) next = STATE_FETCH;
            end
            STATE_BRANCH: begin
                alu_op   = OP_SUB;
                alu_src  = ALU_SRC_REG;
                pc_src   = PC_SRC_BRANCH;
                pc_write = (opcode == OPC_BNE) ? !alu_zero : alu_zero;
                next     = STATE_FETCH;
            end
            STATE_JUMP: begin
                pc_write = 1'b1;
                pc_src   = is_jr ? PC_SRC_REG : PC_SRC_JUMP26;
                // jal links the PC that FETCH already advanced
                if (opcode == OPC_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = REG_DST_RA;
                    wb_src    = WB_SRC_PC;
                end
                next = STATE_FETCH;
            end
            STATE_TRAP: illegal = 1'b1;
            default: next = STATE_RESET;
        endcase
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the MIPS processor datapath. It replaces single-cycle decode-and-execute with an FSM that shares one memory port and one ALU across fetch, execute, memory and write-back steps, and drives every datapath strobe and mux select. It sits between the instruction register/memory interface and the register file/ALU/PC datapath.

## Interface
No parameters; the supported opcode set is fixed.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `instruction` in 32: IR contents, valid from DECODE onward.
- `mem_ready` in 1: memory completes the current request this cycle.
- `alu_zero` in 1: ALU result == 0.
- `mem_req` out 1: memory request; held until `mem_ready`.
- `mem_we` out 1: write (sw) when 1, read when 0.
- `mem_addr_sel` out 1: 0 = PC, 1 = ALU result.
- `ir_write` out 1: load IR.
- `pc_write` out 1: load PC.
- `pc_src` out 2: `PC_SRC_PLUS4`, `PC_SRC_BRANCH`, `PC_SRC_JUMP26`, `PC_SRC_REG`.
- `reg_write` out 1: register file write enable.
- `reg_dst` out 2: `REG_DST_RT`, `REG_DST_RD`, `REG_DST_RA` (31).
- `wb_src` out 2: `WB_SRC_ALU`, `WB_SRC_MEM`, `WB_SRC_PC`.
- `alu_src` out 2: `ALU_SRC_*` codes.
- `alu_op` out 3: `OP_*` codes.
- `illegal` out 1: sticky; set when an unsupported opcode or funct is decoded.
- `state` out 4: current state, for debug.

## Operation
- **Supported instructions:**
  - R-type funct: add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27, slt 0x2A, sll 0x00, srl 0x02, jr 0x08.
  - Opcodes: addi 0x08, andi 0x0C, ori 0x0D, beq 0x04, bne 0x05, lw 0x23, sw 0x2B, j 0x02, jal 0x03.
- **States:** RESET, FETCH, DECODE, EXEC, WB_ALU, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, TRAP.
- **RESET:** all outputs 0. Moves to FETCH on the first edge after `reset` deasserts.
- **FETCH:** `mem_req`=1, `mem_addr_sel`=0, `mem_we`=0. In the cycle `mem_ready`=1, also assert `ir_write`=1, `pc_write`=1, `pc_src`=PLUS4, then go to DECODE. Otherwise stay in FETCH.
- **DECODE:** 1 cycle, no strobes. Dispatch:
  - ALU ops → EXEC.
  - lw/sw → MEM_ADDR.
  - beq/bne → BRANCH.
  - j/jal/jr → JUMP.
  - Anything else → TRAP.
- **EXEC:** drive `alu_op`/`alu_src` per instruction.
  - addi: SEXT_IMM16.
  - andi/ori: ZEXT_IMM16.
  - sll/srl: shamt source.
  - R-type: register source.
  - Next state WB_ALU.
- **WB_ALU:** same ALU controls as EXEC, plus `reg_write`=1, `wb_src`=ALU. `reg_dst`=RD for R-type, RT for immediates. Next state FETCH.
- **MEM_ADDR:** `alu_op`=ADD, `alu_src`=SEXT_IMM16. lw → MEM_READ, sw → MEM_WRITE.
- **MEM_READ / MEM_WRITE:** `mem_req`=1, `mem_addr_sel`=1; `mem_we`=1 only in MEM_WRITE. On `mem_ready`: MEM_READ → MEM_WB, MEM_WRITE → FETCH.
- **MEM_WB:** `reg_write`=1, `wb_src`=MEM, `reg_dst`=RT. Next state FETCH.
- **BRANCH:** `alu_op`=SUB, `alu_src`=register. `pc_write` = `alu_zero` for beq, `!alu_zero` for bne, with `pc_src`=BRANCH. Next state FETCH.
- **JUMP:** `pc_write`=1.
  - j: `pc_src`=JUMP26.
  - jal: `pc_src`=JUMP26, plus `reg_write`=1, `reg_dst`=RA, `wb_src`=PC (the already-incremented PC).
  - jr: `pc_src`=REG, `reg_write`=0.
  - Next state FETCH.
- **TRAP:** all outputs 0, `illegal`=1. Stays in TRAP until `reset`.
- **Don't-care outputs:** any output not named for a state is 0.

## Timing
- **State register:** updates on `posedge clk`; `reset` forces RESET asynchronously. All outputs are combinational from `state` + `instruction` + `alu_zero` (Moore except the branch `pc_write`).
- **Latency with zero-wait memory** (`mem_ready` high on the first request cycle):
  - ALU op: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne: 3 cycles.
  - j/jal/jr: 3 cycles.
  - Each wait cycle adds 1.
- **Memory handshake:**
  - `mem_req`, `mem_we` and `mem_addr_sel` stay stable until `mem_ready`; the request is never withdrawn early.
  - `mem_ready` is ignored when `mem_req`=0.
- **Reset mid-operation** (including a memory wait): `mem_req` and all write strobes drop in the same cycle `reset` rises. No PC, IR or register write occurs. `illegal` clears.
- **Instruction stability:** `instruction` changes only on `ir_write` edges, so decode is stable from DECODE through the last execute state.

## Structure
- `_const.v` keeps `OP_*` and `ALU_SRC_*`, and gains `STATE_*`, `PC_SRC_*`, `REG_DST_*`, `WB_SRC_*`, plus opcode/funct constants.
- Sub-module `mc_alu_decode`: combinational map of opcode/funct to `alu_op`, `alu_src` and a legal flag. It is shared with EXEC, WB_ALU and DECODE dispatch.

## Test plan
- **Reset then addi** `0x2010FEFE`, zero-wait memory: RESET, FETCH (ir_write, pc_write), DECODE, EXEC (alu_src=SEXT_IMM16, alu_op=OP_ADD), then WB_ALU with reg_write=1, reg_dst=RT.
- **lw** `0x8D090004` with `mem_ready` low for 3 cycles in MEM_READ: `mem_req`=1, `mem_addr_sel`=1 held for 4 cycles; MEM_WB asserts wb_src=MEM; total 8 cycles.
- **Branches:**
  - beq `0x11090003` with alu_zero=1: pc_write=1, pc_src=BRANCH.
  - bne `0x15090003` with alu_zero=1: pc_write=0.
- **jal** `0x0C000004`: JUMP cycle shows pc_src=JUMP26, reg_write=1, reg_dst=RA, wb_src=PC.
- **Illegal opcode** `0xFC000000`: TRAP, illegal=1, all strobes 0 for 10 cycles; `reset` clears it.
- **Reset mid-wait:** assert `reset` during FETCH with `mem_ready`=0; mem_req falls within the cycle, and FETCH resumes 1 cycle after release.
